pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic, parametrised pipeline stage register; successor to the fixed-field per-stage registers.
//  Carries a control word (zeroed on flush to form a bubble) and a data payload.
//  Valid/ready handshake replaces the unconditional per-cycle load; optional 2-entry skid slot.
//  Instanced between IF/ID, ID/EXE, EXE/MEM and MEM/WB with per-stage widths.
// PARAMETERS
//  CTRL_W   8   control-field width (RegWrite, MemRead, ALUOp...); forced to 0 on flush/reset
//  DATA_W   111 payload width (operands, immediate, register indices); forced to 0 on flush/reset
//  SKID     1   1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
//  CNT_W    16  width of the saturating stall-cycle counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  flush      in   1       synchronous squash of all held entries
//  in_valid   in   1       upstream beat present
//  in_ready   out  1       stage can accept a beat this cycle
//  in_ctrl    in   CTRL_W  upstream control word
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       output beat present
//  out_ready  in   1       downstream accepts output beat
//  out_ctrl   out  CTRL_W  registered control word (0 when out_valid=0)
//  out_data   out  DATA_W  registered payload (0 when out_valid=0)
//  stall_cnt  out  CNT_W   cycles with out_valid=1 && out_ready=0, saturating
// BEHAVIOUR
//  - Clock is clk; reset is rst, asynchronous, active-high.
//  - Reset (async): out_valid=0, out_ctrl=0, out_data=0, skid empty, stall_cnt=0.
//    in_ready=1 (SKID=1) once rst is released; SKID=0 in_ready is comb (=1 when empty).
//  - Transfer in: in_valid && in_ready at rising edge; transfer out: out_valid && out_ready.
//  - Latency: 1 cycle, empty stage -> beat on out_* on the edge after acceptance.
//  - Ordering strictly FIFO; no beat duplicated or dropped except by flush.
//  - SKID=1 states: EMPTY -> (accept) FULL; FULL & accept & !deq -> SKID_FULL (beat to skid);
//    FULL & deq & !accept -> EMPTY; FULL & deq & accept -> FULL (new beat to main);
//    SKID_FULL & deq -> FULL (skid moves to main); in_ready = (state != SKID_FULL), registered.
//  - SKID=0: in_ready = !out_valid || out_ready; max one entry; states EMPTY/FULL only.
//  - Flush (sync, highest priority after rst): next state EMPTY, out_valid=0, out_ctrl=0,
//    out_data=0, skid cleared; a beat offered in the flush cycle is dropped (not accepted
//    even if in_ready=1); in_ready=1 the cycle after. stall_cnt not cleared by flush.
//  - Simultaneous accept + dequeue in FULL: both happen, occupancy unchanged.
//  - out_ctrl/out_data must read 0 whenever out_valid=0 (bubble is all-zero, never stale).
//  - Upstream must hold in_* stable while in_valid && !in_ready; block does not check.
//  - stall_cnt increments by 1 each cycle out_valid && !out_ready; holds at 2^CNT_W-1.
//  - Reset mid-operation: all entries lost immediately, outputs zero without a clock edge.
// STRUCTURE
//  - Shared package pipe_pkg: state enum {ST_EMPTY, ST_FULL, ST_SKID_FULL}, LENGTH=32,
//    per-stage CTRL_W/DATA_W localparams for IF/ID, ID/EXE, EXE/MEM, MEM/WB instances.
//  - One sub-module: pipe_sat_cnt (CNT_W saturating counter, async rst, inc enable).
//  - Main and skid slots are flat {ctrl,data} registers in this module; SKID=0 removes skid via generate.
// TESTING
//  - Reset: rst=1 mid-stream with FULL state -> out_valid=0, out_ctrl=0, out_data=0 same cycle,
//    stall_cnt=0.
//  - Streaming: in_valid=1 every cycle, out_ready=1, data 1..8 -> out_data 1..8 one cycle
//    later, back-to-back, in_ready always 1.
//  - Backpressure (SKID=1): out_ready=0 from cycle 3, send A,B,C -> A held on out, B in skid,
//    in_ready=0, C held upstream; release -> A,B,C in order; stall_cnt equals stalled cycles.
//  - Flush in SKID_FULL with in_valid=1 (beat D) -> next cycle out_valid=0, out_ctrl=0,
//    in_ready=1, D never appears on output.
//  - SKID=0: out_ready=0 with FULL -> in_ready=0 combinationally; out_ready=1 same cycle ->
//    in_ready=1, accept + dequeue same edge.
//  - Saturation: CNT_W=4, hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy states and
// per-stage field widths for the four inter-stage instances.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_t;

  localparam int LENGTH = 32;
  localparam int REG_IDX_W = 5;

  // IF/ID carries pc + instruction; ID/EXE carries two operands, immediate and three indices.
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 2 * LENGTH;
  localparam int IDEXE_CTRL_W = 8;
  localparam int IDEXE_DATA_W = 3 * LENGTH + 3 * REG_IDX_W;
  localparam int EXEMEM_CTRL_W = 4;
  localparam int EXEMEM_DATA_W = 2 * LENGTH + REG_IDX_W;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 2 * LENGTH + REG_IDX_W;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with asynchronous reset; holds at all-ones.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid slot, flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int SLOT_W = CTRL_W + DATA_W;

  // Handshake: a beat moves in when in_valid && in_ready at a rising edge (and no
  // flush that cycle); it moves out when out_valid && out_ready. in_* must be held
  // by upstream while in_valid && !in_ready.
  state_t            state_q;
  state_t            state_d;
  logic [SLOT_W-1:0] main_q;
  logic [SLOT_W-1:0] skid_q;
  logic [SLOT_W-1:0] in_slot;
  logic              accept;
  logic              deq;
  logic              load_main_in;
  logic              load_main_skid;

  assign in_slot   = {in_ctrl, in_data};
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready;

  // Masking keeps a bubble all-zero even if main_q ever held stale content.
  assign {out_ctrl, out_data} = out_valid ? main_q : '0;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic ready_q;

      always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_d      = ST_FULL;
                load_main_in = 1'b1;
              end
            end
            ST_FULL: begin
              if (accept && deq) begin
                load_main_in = 1'b1;
              end else if (accept) begin
                state_d   = ST_SKID_FULL;
                skid_load = 1'b1;
              end else if (deq) begin
                state_d = ST_EMPTY;
              end
            end
            ST_SKID_FULL: begin
              if (deq) begin
                state_d        = ST_FULL;
                load_main_skid = 1'b1;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      // in_ready is registered from the next state so it never depends on out_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_q  <= '0;
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != ST_SKID_FULL);
          if (flush) begin
            skid_q <= '0;
          end else if (skid_load) begin
            skid_q <= in_slot;
          end
        end
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_d      = ST_FULL;
                load_main_in = 1'b1;
              end
            end
            ST_FULL: begin
              if (accept) begin
                load_main_in = 1'b1;
              end else if (deq) begin
                state_d = ST_EMPTY;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      assign skid_q   = '0;
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        main_q <= '0;
      end else if (load_main_in) begin
        main_q <= in_slot;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end else if (deq && (state_d == ST_EMPTY)) begin
        main_q <= '0;
      end
    end
  end

  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance,
// each tracked by a queue-based occupancy model with a capacity rule.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 111;
  localparam int SW = CW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush1, iv1, ir1, ov1, or1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [3:0]    sc1;

  logic          flush0, iv0, ir0, ov0, or0;
  logic [CW-1:0] ic0, oc0;
  logic [DW-1:0] id0, od0;
  logic [15:0]   sc0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
    .in_ctrl(ic1), .in_data(id1), .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .in_ctrl(ic0), .in_data(id0), .out_valid(ov0), .out_ready(or0),
    .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0)
  );

  logic [SW-1:0] exp_q1[$];
  logic [SW-1:0] exp_q0[$];
  logic [3:0]    c1;
  logic [15:0]   c0;
  logic          a1, a0;
  int            n_cmp, n_err;

  function automatic logic [DW-1:0] rdata();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic logic [SW-1:0] head1();
    return (exp_q1.size() > 0) ? exp_q1[0] : '0;
  endfunction

  function automatic logic [SW-1:0] head0();
    return (exp_q0.size() > 0) ? exp_q0[0] : '0;
  endfunction

  // Model: skid stage holds up to 2 beats, no-skid stage 1 beat (or 1 + same-edge dequeue).
  task automatic tick();
    logic r1, r0;
    r1 = (exp_q1.size() < 2);
    r0 = (exp_q0.size() == 0) || or0;
    a1 = iv1 && r1 && !flush1;
    a0 = iv0 && r0 && !flush0;
    if (exp_q1.size() > 0 && !or1 && c1 != 4'hf) c1 = c1 + 4'd1;
    if (exp_q0.size() > 0 && !or0 && c0 != 16'hffff) c0 = c0 + 16'd1;
    if (flush1) exp_q1.delete();
    else begin
      if (exp_q1.size() > 0 && or1) void'(exp_q1.pop_front());
      if (a1) exp_q1.push_back({ic1, id1});
    end
    if (flush0) exp_q0.delete();
    else begin
      if (exp_q0.size() > 0 && or0) void'(exp_q0.pop_front());
      if (a0) exp_q0.push_back({ic0, id0});
    end
    @(posedge clk);
  endtask

  task automatic clear_model();
    exp_q1.delete();
    exp_q0.delete();
    c1 = '0;
    c0 = '0;
    a1 = 1'b0;
    a0 = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] a;
    @(negedge clk); #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
    n_cmp++; if ({oc1, od1} !== '0) begin n_err++; $display("FAIL reset_out1 got %h exp 0", {oc1, od1}); end
    n_cmp++; if (sc1 !== 4'd0) begin n_err++; $display("FAIL reset_sc1 got %0d exp 0", sc1); end
    n_cmp++; if (ir0 !== 1'b1) begin n_err++; $display("FAIL reset_ir0 got %b exp 1", ir0); end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    #1;
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL post_reset_ir1 got %b exp 1", ir1); end
    tick();
    @(negedge clk);
    a = rdata();
    iv1 = 1'b1; ic1 = 8'h5a; id1 = a; or1 = 1'b0;
    tick();
    @(negedge clk);
    iv1 = 1'b0;
    #1;
    n_cmp++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL full_ov1 got %b exp 1", ov1); end
    n_cmp++; if (od1 !== a) begin n_err++; $display("FAIL full_od1 got %h exp %h", od1, a); end
    tick();
    @(negedge clk); #1;
    n_cmp++; if (sc1 !== 4'd1) begin n_err++; $display("FAIL pre_rst_sc1 got %0d exp 1", sc1); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL async_rst_ov1 got %b exp 0", ov1); end
    n_cmp++; if ({oc1, od1} !== '0) begin n_err++; $display("FAIL async_rst_out1 got %h exp 0", {oc1, od1}); end
    n_cmp++; if (sc1 !== 4'd0) begin n_err++; $display("FAIL async_rst_sc1 got %0d exp 0", sc1); end
    clear_model();
    or1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      iv1 = (k <= 8); ic1 = 8'(k); id1 = DW'(k); or1 = 1'b1;
      #1;
      if (k <= 8) begin
        n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL stream_ir1 k=%0d got %b exp 1", k, ir1); end
      end
      if (k == 1) begin
        n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL stream_first_ov1 got %b exp 0", ov1); end
      end else begin
        n_cmp++; if (ov1 !== 1'b1) begin n_err++; $display("FAIL stream_ov1 k=%0d got %b exp 1", k, ov1); end
        n_cmp++; if (od1 !== DW'(k - 1)) begin n_err++; $display("FAIL stream_od1 k=%0d got %0d exp %0d", k, od1, k - 1); end
        n_cmp++; if (oc1 !== 8'(k - 1)) begin n_err++; $display("FAIL stream_oc1 k=%0d got %0d exp %0d", k, oc1, k - 1); end
      end
      tick();
    end
    iv1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    a = rdata(); b = rdata(); c = rdata();
    @(negedge clk);
    iv1 = 1'b1; ic1 = 8'h0a; id1 = a; or1 = 1'b0;
    tick();
    @(negedge clk);
    ic1 = 8'h0b; id1 = b;
    #1;
    n_cmp++; if (od1 !== a) begin n_err++; $display("FAIL bp_a_out got %h exp %h", od1, a); end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ic1 = 8'h0c; id1 = c;
      #1;
      n_cmp++; if (ir1 !== 1'b0) begin n_err++; $display("FAIL bp_ir1 i=%0d got %b exp 0", i, ir1); end
      n_cmp++; if (od1 !== a) begin n_err++; $display("FAIL bp_hold_a i=%0d got %h exp %h", i, od1, a); end
      tick();
    end
    @(negedge clk);
    or1 = 1'b1;
    #1;
    n_cmp++; if (sc1 !== 4'd5) begin n_err++; $display("FAIL bp_stall_cnt got %0d exp 5", sc1); end
    n_cmp++; if (od1 !== a) begin n_err++; $display("FAIL bp_rel_a got %h exp %h", od1, a); end
    tick();
    @(negedge clk); #1;
    n_cmp++; if ({oc1, od1} !== {8'h0b, b}) begin n_err++; $display("FAIL bp_rel_b got %h exp %h", {oc1, od1}, {8'h0b, b}); end
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL bp_rel_ir1 got %b exp 1", ir1); end
    tick();
    @(negedge clk);
    iv1 = 1'b0;
    #1;
    n_cmp++; if ({oc1, od1} !== {8'h0c, c}) begin n_err++; $display("FAIL bp_rel_c got %h exp %h", {oc1, od1}, {8'h0c, c}); end
    tick();
    @(negedge clk); #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b exp 0", ov1); end
    n_cmp++; if (sc1 !== 4'd5) begin n_err++; $display("FAIL bp_stall_final got %0d exp 5", sc1); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    iv1 = 1'b1; ic1 = 8'he1; id1 = rdata(); or1 = 1'b0;
    tick();
    @(negedge clk);
    ic1 = 8'hf2; id1 = rdata();
    tick();
    @(negedge clk);
    flush1 = 1'b1; ic1 = 8'hdd; id1 = rdata();
    #1;
    n_cmp++; if (ir1 !== 1'b0) begin n_err++; $display("FAIL flush_pre_ir1 got %b exp 0", ir1); end
    tick();
    @(negedge clk);
    flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL flush_ov1 got %b exp 0", ov1); end
    n_cmp++; if ({oc1, od1} !== '0) begin n_err++; $display("FAIL flush_out1 got %h exp 0", {oc1, od1}); end
    n_cmp++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL flush_ir1 got %b exp 1", ir1); end
    n_cmp++; if (sc1 !== c1) begin n_err++; $display("FAIL flush_sc1 got %0d exp %0d", sc1, c1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk); #1;
      n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL flush_no_d i=%0d got %b exp 0", i, ov1); end
    end
  endtask

  task automatic test_noskid();
    logic [DW-1:0] x, y;
    x = rdata(); y = rdata();
    @(negedge clk);
    iv0 = 1'b1; ic0 = 8'h11; id0 = x; or0 = 1'b0;
    tick();
    @(negedge clk);
    ic0 = 8'h22; id0 = y; or0 = 1'b0;
    #1;
    n_cmp++; if (ir0 !== 1'b0) begin n_err++; $display("FAIL ns_ir0_blocked got %b exp 0", ir0); end
    n_cmp++; if ({oc0, od0} !== {8'h11, x}) begin n_err++; $display("FAIL ns_x_out got %h exp %h", {oc0, od0}, {8'h11, x}); end
    or0 = 1'b1;
    #1;
    n_cmp++; if (ir0 !== 1'b1) begin n_err++; $display("FAIL ns_ir0_comb got %b exp 1", ir0); end
    tick();
    @(negedge clk);
    iv0 = 1'b0;
    #1;
    n_cmp++; if (ov0 !== 1'b1) begin n_err++; $display("FAIL ns_y_valid got %b exp 1", ov0); end
    n_cmp++; if ({oc0, od0} !== {8'h22, y}) begin n_err++; $display("FAIL ns_y_out got %h exp %h", {oc0, od0}, {8'h22, y}); end
    tick();
    @(negedge clk); #1;
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL ns_drained got %b exp 0", ov0); end
    n_cmp++; if (sc0 !== 16'd0) begin n_err++; $display("FAIL ns_sc0 got %0d exp 0", sc0); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] z;
    z = rdata();
    @(negedge clk);
    iv1 = 1'b1; ic1 = 8'h33; id1 = z; or1 = 1'b0;
    tick();
    @(negedge clk);
    iv1 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk); #1;
    n_cmp++; if (sc1 !== 4'd15) begin n_err++; $display("FAIL sat_sc1 got %0d exp 15", sc1); end
    n_cmp++; if (od1 !== z) begin n_err++; $display("FAIL sat_hold got %h exp %h", od1, z); end
    or1 = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      or1 = ($urandom_range(0, 3) != 0);
      or0 = ($urandom_range(0, 3) != 0);
      flush1 = ($urandom_range(0, 24) == 0);
      flush0 = ($urandom_range(0, 24) == 0);
      if (!(iv1 && !a1)) begin
        iv1 = ($urandom_range(0, 3) != 0); ic1 = 8'($urandom); id1 = rdata();
      end
      if (!(iv0 && !a0)) begin
        iv0 = ($urandom_range(0, 3) != 0); ic0 = 8'($urandom); id0 = rdata();
      end
      #1;
      n_cmp++; if (ov1 !== (exp_q1.size() > 0)) begin n_err++; $display("FAIL rnd_ov1 i=%0d got %b", i, ov1); end
      n_cmp++; if ({oc1, od1} !== head1()) begin n_err++; $display("FAIL rnd_out1 i=%0d got %h exp %h", i, {oc1, od1}, head1()); end
      n_cmp++; if (ir1 !== (exp_q1.size() < 2)) begin n_err++; $display("FAIL rnd_ir1 i=%0d got %b", i, ir1); end
      n_cmp++; if (sc1 !== c1) begin n_err++; $display("FAIL rnd_sc1 i=%0d got %0d exp %0d", i, sc1, c1); end
      n_cmp++; if (ov0 !== (exp_q0.size() > 0)) begin n_err++; $display("FAIL rnd_ov0 i=%0d got %b", i, ov0); end
      n_cmp++; if ({oc0, od0} !== head0()) begin n_err++; $display("FAIL rnd_out0 i=%0d got %h exp %h", i, {oc0, od0}, head0()); end
      n_cmp++; if (ir0 !== ((exp_q0.size() == 0) || or0)) begin n_err++; $display("FAIL rnd_ir0 i=%0d got %b", i, ir0); end
      n_cmp++; if (sc0 !== c0) begin n_err++; $display("FAIL rnd_sc0 i=%0d got %0d exp %0d", i, sc0, c0); end
      tick();
    end
    @(negedge clk);
    iv1 = 1'b0; iv0 = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b1; ic1 = '0; id1 = '0;
    flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b1; ic0 = '0; id0 = '0;
    clear_model();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_noskid();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
